// File: rtl/ysyx_25030085_lsu_pkg.sv
// Shared definitions for the load/store unit: MemOp encodings (common with the decoder),
// FSM state encodings, bus response codes and request legality helpers.
package ysyx_25030085_lsu_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Unsigned variants only make sense for loads; stores accept b/h/w only.
  function automatic logic op_is_legal(input logic wen, input logic [2:0] op);
    case (op)
      MEM_B, MEM_H, MEM_W: return 1'b1;
      MEM_BU, MEM_HU:      return !wen;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op)
      MEM_H, MEM_HU: return addr_lo[0];
      MEM_W:         return addr_lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// Combinational lane logic: store data replication and byte strobes, and load lane
// extraction with sign/zero extension.
module ysyx_25030085_lsu_align
  import ysyx_25030085_lsu_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Strobes are 4 bits wide, so anything shifted past lane 3 simply falls off.
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (st_op)
      MEM_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_addr_lo;
      end
      MEM_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = 8'(ld_rdata >> {ld_addr_lo, 3'b000});
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_op)
      MEM_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_H:   ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_BU:  ld_data = {24'h0, ld_byte};
      MEM_HU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: one core request at a time turned into an AXI4-Lite-style bus transaction.
// Optional: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses without bus traffic.
module ysyx_25030085_lsu
  import ysyx_25030085_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_e              state_q, state_d;
  logic                wen_q, wen_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                req_ready_q, req_ready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                resp_valid_q, resp_valid_d;

  logic [31:0]         st_wdata;
  logic [3:0]          st_wstrb;
  logic [31:0]         ld_data;
  logic                misalign;

  ysyx_25030085_lsu_align u_align (
    .st_op      (req_op),
    .st_addr_lo (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_wdata   (st_wdata),
    .st_wstrb   (st_wstrb),
    .ld_op      (op_q),
    .ld_addr_lo (addr_q[1:0]),
    .ld_rdata   (rdata),
    .ld_data    (ld_data)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = op_is_misaligned(req_op, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          wen_d     = req_wen;
          op_d      = req_op;
          addr_d    = req_addr;
          wdata_d   = '0;
          wstrb_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b0;
          if (!op_is_legal(req_wen, req_op) || misalign) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (req_wen) begin
            state_d = WR_AW;
            wdata_d = st_wdata;
            wstrb_d = st_wstrb;
          end else begin
            state_d = RD_A;
          end
        end
      end
      RD_A: if (arready) state_d = RD_D;
      RD_D: begin
        if (rvalid) begin
          rdata_d = ld_data;
          err_d   = (rresp != RESP_OKAY);
          state_d = RESP;
        end
      end
      // Address and data handshakes complete independently, possibly in the same cycle.
      WR_AW: begin
        aw_done_d = aw_done_q | (awvalid_q & awready);
        w_done_d  = w_done_q | (wvalid_q & wready);
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        if (bvalid) begin
          rdata_d = '0;
          err_d   = (bresp != RESP_OKAY);
          state_d = RESP;
        end
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state so they are glitch-free
    // and stay stable while waiting for the other side.
    req_ready_d  = (state_d == IDLE);
    arvalid_d    = (state_d == RD_A);
    rready_d     = (state_d == RD_D);
    awvalid_d    = (state_d == WR_AW) && !aw_done_d;
    wvalid_d     = (state_d == WR_AW) && !w_done_d;
    bready_d     = (state_d == WR_B);
    resp_valid_d = (state_d == RESP);
  end

  // NOTE: async reset clears every flop, so all outputs (req_ready included) read 0 while
  // reset is high; state flops use non-blocking assignments so all update on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign araddr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awaddr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Directed bench for ysyx_25030085_lsu: vector table of single transactions with an
// immediate bus, plus hand-written stall, error and mid-transaction reset sequences.
module tb_ysyx_25030085_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  ysyx_25030085_lsu dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_resp;
    logic [31:0] exp_baddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] obs_araddr, obs_awaddr, obs_wdata, got_rdata;
  logic [3:0]  obs_wstrb;
  logic        got_err;
  int          ar_hs, aw_hs, w_hs, b_hs, aw_cyc, w_cyc, lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] brd, input logic [1:0] bresp_v,
                              input logic [31:0] baddr, input logic [31:0] ewd, input logic [3:0] estrb,
                              input logic [31:0] erd, input logic eerr, input int elat);
    vec_t v;
    v.wen = wen; v.op = op; v.addr = addr; v.wdata = wd; v.bus_rdata = brd; v.bus_resp = bresp_v;
    v.exp_baddr = baddr; v.exp_wdata = ewd; v.exp_wstrb = estrb; v.exp_rdata = erd;
    v.exp_err = eerr; v.exp_lat = elat;
    return v;
  endfunction

  task automatic clear_bus();
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; resp_ready = 0;
  endtask

  task automatic wait_req_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clock); @(negedge clock); n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Issues one request at a negedge and plays the bus slave with per-channel delays.
  task automatic run_txn(input vec_t v, input int aw_dly, input int w_dly, input int r_dly,
                         input int b_dly, input int resp_hold);
    int  r_c = 0, b_c = 0, hold = 0;
    bit  done = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; aw_cyc = 0; w_cyc = 0; lat = 0;
    got_rdata = 'x; got_err = 'x;
    wait_req_ready();
    req_valid = 1; req_wen = v.wen; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clock); @(negedge clock);
    req_valid = 0; req_wdata = 32'h0;
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      arready = arvalid;
      if (arvalid) begin ar_hs++; obs_araddr = araddr; end
      rvalid = rready && (r_c >= r_dly);
      if (rready) r_c++;
      rdata = rvalid ? v.bus_rdata : 32'h0;
      rresp = rvalid ? v.bus_resp : 2'b00;
      awready = awvalid && (aw_cyc >= aw_dly);
      if (awvalid) begin aw_cyc++; obs_awaddr = awaddr; end
      if (awready) aw_hs++;
      wready = wvalid && (w_cyc >= w_dly);
      if (wvalid) begin w_cyc++; obs_wdata = wdata; obs_wstrb = wstrb; end
      if (wready) w_hs++;
      bvalid = bready && (b_c >= b_dly);
      if (bready) b_c++;
      bresp = bvalid ? v.bus_resp : 2'b00;
      if (bvalid) b_hs++;
      if (lat != 0) check("resp_valid_held", 32'(resp_valid), 32'd1);
      if (resp_valid) begin
        if (lat == 0) lat = cyc;
        if (hold < resp_hold) begin
          hold++;
          resp_ready = 0;
          check("hold_req_ready", 32'(req_ready), 32'd0);
        end else begin
          resp_ready = 1;
          got_rdata  = resp_rdata;
          got_err    = resp_err;
          done       = 1;
        end
      end
      @(posedge clock); @(negedge clock);
    end
    clear_bus();
    if (!done) check("txn_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    bit bus = (v.exp_lat != 1);
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_rdata"}, got_rdata, v.exp_rdata);
    check({tag, "_err"}, 32'(got_err), 32'(v.exp_err));
    check({tag, "_ar_hs"}, 32'(ar_hs), 32'(bus && !v.wen));
    check({tag, "_aw_hs"}, 32'(aw_hs), 32'(bus && v.wen));
    check({tag, "_w_hs"}, 32'(w_hs), 32'(bus && v.wen));
    check({tag, "_b_hs"}, 32'(b_hs), 32'(bus && v.wen));
    if (bus && !v.wen) check({tag, "_araddr"}, obs_araddr, v.exp_baddr);
    if (bus && v.wen) begin
      check({tag, "_awaddr"}, obs_awaddr, v.exp_baddr);
      check({tag, "_wdata"}, obs_wdata, v.exp_wdata);
      check({tag, "_wstrb"}, 32'(obs_wstrb), 32'(v.exp_wstrb));
    end
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;

    //         wen op      addr          wdata         bus_rdata     resp   baddr         exp_wdata     strb     exp_rdata     err lat
    vecs.push_back(mk(0, 3'b000, 32'h8000_0003, 32'h0,        32'h80AB_CDEF, 2'b00, 32'h8000_0000, 32'h0,        4'b0000, 32'hFFFF_FF80, 0, 3));
    vecs.push_back(mk(0, 3'b101, 32'h8000_0002, 32'h0,        32'h9234_5678, 2'b00, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_9234, 0, 3));
    vecs.push_back(mk(0, 3'b001, 32'h8000_0002, 32'h0,        32'h9234_5678, 2'b00, 32'h8000_0000, 32'h0,        4'b0000, 32'hFFFF_9234, 0, 3));
    vecs.push_back(mk(0, 3'b001, 32'h8000_0010, 32'h0,        32'h9234_5678, 2'b00, 32'h8000_0010, 32'h0,        4'b0000, 32'h0000_5678, 0, 3));
    vecs.push_back(mk(0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 2'b00, 32'h8000_0004, 32'h0,        4'b0000, 32'hDEAD_BEEF, 0, 3));
    vecs.push_back(mk(0, 3'b100, 32'h8000_0001, 32'h0,        32'h80AB_CDEF, 2'b00, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_00CD, 0, 3));
    vecs.push_back(mk(0, 3'b000, 32'h1000_0000, 32'h0,        32'h0000_007F, 2'b00, 32'h1000_0000, 32'h0,        4'b0000, 32'h0000_007F, 0, 3));
    vecs.push_back(mk(0, 3'b010, 32'h8000_0008, 32'h0,        32'h1122_3344, 2'b10, 32'h8000_0008, 32'h0,        4'b0000, 32'h1122_3344, 1, 3));
    vecs.push_back(mk(1, 3'b000, 32'h8000_0101, 32'h1234_56AA, 32'h0,       2'b00, 32'h8000_0100, 32'hAAAA_AAAA, 4'b0010, 32'h0,         0, 3));
    vecs.push_back(mk(1, 3'b001, 32'h8000_0202, 32'hCAFE_BEEF, 32'h0,       2'b00, 32'h8000_0200, 32'hBEEF_BEEF, 4'b1100, 32'h0,         0, 3));
    vecs.push_back(mk(1, 3'b010, 32'h8000_0300, 32'h0123_4567, 32'h0,       2'b00, 32'h8000_0300, 32'h0123_4567, 4'b1111, 32'h0,         0, 3));
    vecs.push_back(mk(0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,         2'b00, 32'h0,         32'h0,        4'b0000, 32'h0,         1, 1));
    vecs.push_back(mk(1, 3'b100, 32'h8000_0000, 32'h5555_5555, 32'h0,       2'b00, 32'h0,         32'h0,        4'b0000, 32'h0,         1, 1));
    vecs.push_back(mk(0, 3'b111, 32'h8000_0000, 32'h0,        32'h0,         2'b00, 32'h0,         32'h0,        4'b0000, 32'h0,         1, 1));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 3'b010, 32'h8000_0002, 32'h0,        32'hA5A5_0F0F, 2'b00, 32'h0,         32'h0,        4'b0000, 32'h0,         1, 1));
    vecs.push_back(mk(1, 3'b001, 32'h8000_0003, 32'h0000_1234, 32'h0,       2'b00, 32'h0,         32'h0,        4'b0000, 32'h0,         1, 1));
`else
    vecs.push_back(mk(0, 3'b010, 32'h8000_0002, 32'h0,        32'hA5A5_0F0F, 2'b00, 32'h8000_0000, 32'h0,        4'b0000, 32'hA5A5_0F0F, 0, 3));
    vecs.push_back(mk(1, 3'b001, 32'h8000_0003, 32'h0000_1234, 32'h0,       2'b00, 32'h8000_0000, 32'h1234_1234, 4'b1100, 32'h0,         0, 3));
`endif

    reset = 1; req_valid = 0; req_wen = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    clear_bus();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_handshakes", 32'({req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    check("reset_bus_data", araddr | awaddr | wdata | 32'(wstrb) | resp_rdata | 32'(resp_err), 32'd0);
    reset = 0;
    @(posedge clock); @(negedge clock);
    check("post_reset_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      run_txn(vecs[i], 0, 0, 0, 0, 0);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Store byte with AW accepted one cycle before W.
    v = mk(1, 3'b000, 32'h8000_0101, 32'h1234_56AA, 32'h0, 2'b00, 32'h8000_0100, 32'hAAAA_AAAA, 4'b0010, 32'h0, 0, 4);
    run_txn(v, 0, 1, 0, 0, 0);
    check_vec("sb_aw_first", v);
    check("sb_aw_first_awvalid_cycles", 32'(aw_cyc), 32'd1);
    check("sb_aw_first_wvalid_cycles", 32'(w_cyc), 32'd2);

    // Store word: error response after a long B stall, result held off by the core.
    v = mk(1, 3'b010, 32'h8000_0400, 32'hFFFF_0000, 32'h0, 2'b10, 32'h8000_0400, 32'hFFFF_0000, 4'b1111, 32'h0, 1, 8);
    run_txn(v, 0, 0, 0, 5, 3);
    check_vec("sw_berr", v);

    // Reset while waiting in RD_D.
    wait_req_ready();
    req_valid = 1; req_wen = 0; req_op = 3'b010; req_addr = 32'h8000_0020;
    @(posedge clock); @(negedge clock);
    req_valid = 0;
    check("rst_seq_arvalid", 32'(arvalid), 32'd1);
    arready = 1;
    @(posedge clock); @(negedge clock);
    arready = 0;
    check("rst_seq_rready", 32'(rready), 32'd1);
    reset = 1;
    #1;
    check("rst_mid_outputs", 32'({arvalid, rready, resp_valid, req_ready}), 32'd0);
    @(negedge clock);
    reset = 0;
    @(posedge clock); @(negedge clock);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    v = mk(0, 3'b010, 32'h8000_0024, 32'h0, 32'h0BAD_F00D, 2'b00, 32'h8000_0024, 32'h0, 4'b0000, 32'h0BAD_F00D, 0, 3);
    run_txn(v, 0, 0, 0, 0, 0);
    check_vec("post_rst_lw", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030085_lsu.md
Name: ysyx_25030085_lsu

Overview:
- Load/store unit that services the MemRead/MemWrite/MemOp requests produced by the decoder.
- Converts one core request into a word-aligned AXI4-Lite-style bus transaction: lane select, byte strobes, and sign/zero extension of load data.
- Sits between the execute stage and the data-memory bus.
- Handles one request at a time, with valid/ready handshakes on both core and bus sides.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, with 4 byte lanes.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_op  in  3  MemOp: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  effective address (rs1 + imm).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  result valid.
- resp_ready  in  1  core accepts the result.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  bus error or illegal op.
- araddr  out  32, arvalid  out  1, arready  in  1: read address channel.
- rdata  in  32, rresp  in  2, rvalid  in  1, rready  out  1: read data channel.
- awaddr  out  32, awvalid  out  1, awready  in  1: write address channel.
- wdata  out  32, wstrb  out  4, wvalid  out  1, wready  in  1: write data channel.
- bresp  in  2, bvalid  in  1, bready  out  1: write response channel.

Behaviour:
- Reset:
  - All outputs are 0, including req_ready, while reset is high; state = IDLE.
  - Asserting reset mid-transaction drops every valid immediately. Any outstanding bus beat is abandoned; the bus resets together with the LSU.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- IDLE:
  - req_ready = 1. A request is accepted when req_valid && req_ready.
  - On acceptance, latch wen, op, addr and wdata.
- Next state after acceptance:
  - Illegal op (011, 110, 111, or a store with op ≥ 011): go to RESP with resp_err = 1 and no bus activity.
  - Load: go to RD_A.
  - Store: go to WR_AW.
- RD_A:
  - arvalid = 1, araddr = {addr[31:2], 2'b00}.
  - Hold until arready, then go to RD_D.
- RD_D:
  - rready = 1. On rvalid, capture the lane and extend it, and set err = (rresp != 0). Go to RESP.
  - Lane selection: byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]).
  - Extension: ops 000 and 001 sign-extend; ops 100 and 101 zero-extend; 010 passes the word through.
- WR_AW:
  - awvalid and wvalid are asserted together. aw_done and w_done are tracked independently, so each valid drops after its own handshake.
  - Leave for WR_B once both handshakes are complete, including when both complete in the same cycle.
  - awaddr is word-aligned.
  - Write data: for b, wdata = {4{wdata[7:0]}} and wstrb = 4'b0001 << addr[1:0]. For h, wdata = {2{wdata[15:0]}} and wstrb = 4'b0011 << {addr[1], 1'b0}. For w, wstrb = 4'b1111.
- WR_B:
  - bready = 1. On bvalid, set err = (bresp != 0), rdata = 0, and go to RESP.
- RESP:
  - resp_valid is held until resp_ready, then return to IDLE.
  - req_ready is 0 in every state except IDLE, so no request is accepted in the same cycle as the response handshake.
- Latency:
  - Minimum is 3 cycles from acceptance to resp_valid, for both loads (RD_A, RD_D, RESP) and stores.
  - Bus stalls extend latency without bound; no timeout.
- All bus outputs are stable while their valid is high and ready is low.

Optional Feature:
- LSU_MISALIGN_CHECK_EN
  - Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, goes directly to RESP with resp_err = 1 and no bus transaction.
  - Undefined: no check is made; the request is issued with the computed strobe and lane. Strobe bits shifted past lane 3 are truncated, and resp_err reflects only the bus response.

Decomposition:
- Shared package or header holds:
  - MemOp encodings (shared with the decoder).
  - State encodings.
  - RESP_OKAY = 2'b00.
- Sub-module ysyx_25030085_lsu_align, purely combinational: computes wdata replication and wstrb for stores, and lane extraction with extension for loads.

Test Plan:
- Load lb, addr 0x8000_0003, rdata 0x80AB_CDEF, rresp 0 → araddr 0x8000_0000, resp_rdata 0xFFFF_FF80, resp_err 0, resp_valid 3 cycles after acceptance when arready and rvalid are immediate.
- Load lhu, addr 0x8000_0002, rdata 0x9234_5678 → resp_rdata 0x0000_9234. Repeat with lh → 0xFFFF_9234.
- Store sb, addr 0x8000_0101, wdata 0x1234_56AA → awaddr 0x8000_0100, wdata 0xAAAA_AAAA, wstrb 4'b0010. Drive awready one cycle before wready: awvalid drops first, and exactly one B handshake follows.
- Store sw with bresp = 2'b10 and bvalid delayed 5 cycles → resp_err 1, resp_rdata 0. Hold resp_ready low 3 cycles: resp_valid stays high and req_ready stays 0.
- req_op 3'b011 → no arvalid or awvalid, resp_err 1 at RESP. With LSU_MISALIGN_CHECK_EN, lw at 0x8000_0002 → same result.
- Assert reset during RD_D with rvalid low → arvalid, rready, resp_valid and req_ready are all 0 in the same cycle. After release, req_ready = 1 and a fresh lw completes normally.
